// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Word geometry, loader state encoding and the header range check live here.
package instr_loader_pkg;

    localparam int WORD_W         = 22;
    localparam int ADDR_W         = 22;
    localparam int BYTES_PER_WORD = 3;
    localparam int ADDR_SHIFT     = 2;
    localparam int INDEX_W        = 7;
    localparam logic [7:0] MAX_WORDS = 8'd101;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HDR   = 4'd1;
    localparam logic [3:0] S_B0    = 4'd2;
    localparam logic [3:0] S_B1    = 4'd3;
    localparam logic [3:0] S_B2    = 4'd4;
    localparam logic [3:0] S_WRITE = 4'd5;
    localparam logic [3:0] S_CHK   = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE  = S_IDLE,
        ST_HDR   = S_HDR,
        ST_B0    = S_B0,
        ST_B1    = S_B1,
        ST_B2    = S_B2,
        ST_WRITE = S_WRITE,
        ST_CHK   = S_CHK,
        ST_DONE  = S_DONE,
        ST_ERR   = S_ERR
    } loader_state_t;

    function automatic logic count_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= MAX_WORDS);
    endfunction

    function automatic logic accepts_byte(input loader_state_t s);
        logic r;
        case (s)
            ST_HDR, ST_B0, ST_B1, ST_B2, ST_CHK: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input, instruction RAM write port and status flags of the loader.
interface instr_mem_loader_if;
    import instr_loader_pkg::*;

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WORD_W-1:0] mem_wd;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_wa, mem_wd, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_wa, mem_wd, cpu_hold, busy, done, err
    );

endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Collects the three bytes of an instruction word, MSB first, and flags a
// first byte whose unused top bits are set.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [7:0]        i_byte,
    output logic              o_bad_top,
    output logic [WORD_W-1:0] o_word
);

    localparam int HI_W  = WORD_W - 8;
    localparam int TOP_W = 8 * BYTES_PER_WORD - WORD_W;

    logic [HI_W-1:0] r_hi;

    // Older bytes shift left; the two top bits of the first byte fall off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
        end else if (i_clear) begin
            r_hi <= '0;
        end else if (i_load) begin
            r_hi <= {r_hi[HI_W-9:0], i_byte};
        end
    end

    assign o_word    = {r_hi, i_byte};
    assign o_bad_top = |i_byte[7 -: TOP_W];

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a checksummed program image from a byte stream into instruction RAM,
// holding the processor in reset until the image is complete and verified.
module instr_mem_loader
    import instr_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    instr_mem_loader_if.slave  bus
);

    loader_state_t      r_state, w_state_nxt;
    logic               r_in_ready, r_mem_we, r_cpu_hold, r_busy, r_done, r_err;
    logic [ADDR_W-1:0]  r_mem_wa;
    logic [WORD_W-1:0]  r_mem_wd;
    logic [INDEX_W-1:0] r_index;
    logic [7:0]         r_count, r_csum;
    logic               w_hs, w_start, w_last;
    logic               w_asm_clear, w_asm_load, w_bad_top;
    logic [WORD_W-1:0]  w_word;

    assign w_hs   = r_in_ready & bus.in_valid;
    assign w_last = ({1'b0, r_index} == (r_count - 8'd1));

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_asm_clear),
        .i_load    (w_asm_load),
        .i_byte    (bus.in_data),
        .o_bad_top (w_bad_top),
        .o_word    (w_word)
    );

    // Next-state decode and assembler control.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_asm_clear = 1'b0;
        w_asm_load  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    w_start     = 1'b1;
                    w_asm_clear = 1'b1;
                    w_state_nxt = ST_HDR;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_HDR: begin
                if (w_hs) begin
                    w_state_nxt = count_ok(bus.in_data) ? ST_B0 : ST_ERR;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_B0: begin
                if (w_hs) begin
                    w_asm_load  = 1'b1;
                    w_state_nxt = w_bad_top ? ST_ERR : ST_B1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_B1: begin
                if (w_hs) begin
                    w_asm_load  = 1'b1;
                    w_state_nxt = ST_B2;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_B2: begin
                if (w_hs) begin
                    w_asm_load  = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_WRITE: w_state_nxt = w_last ? ST_CHK : ST_B0;
            ST_CHK: begin
                if (w_hs) begin
                    w_state_nxt = (bus.in_data == r_csum) ? ST_DONE : ST_ERR;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs; flags derive from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_wa   <= '0;
            r_mem_wd   <= '0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_index    <= '0;
            r_count    <= 8'd0;
            r_csum     <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= accepts_byte(w_state_nxt);
            r_mem_we   <= (w_state_nxt == ST_WRITE);
            if (w_start) begin
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_busy     <= 1'b1;
                r_cpu_hold <= 1'b1;
                r_index    <= '0;
                r_csum     <= 8'd0;
            end else begin
                // The checksum byte itself is compared, never accumulated.
                if (w_hs && (r_state != ST_CHK)) begin
                    r_csum <= r_csum ^ bus.in_data;
                end
                if (w_hs && (r_state == ST_HDR)) begin
                    r_count <= bus.in_data;
                end
                if (w_hs && (r_state == ST_B2)) begin
                    r_mem_wa <= {{(ADDR_W-INDEX_W-ADDR_SHIFT){1'b0}}, r_index, {ADDR_SHIFT{1'b0}}};
                    r_mem_wd <= w_word;
                end
                if ((r_state == ST_WRITE) && !w_last) begin
                    r_index <= r_index + 7'd1;
                end
                if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE)) begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b0;
                end
                if ((w_state_nxt == ST_ERR) && (r_state != ST_ERR)) begin
                    r_err  <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_wa   = r_mem_wa;
    assign bus.mem_wd   = r_mem_wd;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the 22-bit, word-aligned instruction memory. Receives a program image as a byte stream over a valid/ready handshake and assembles 22-bit instruction words. Checks a trailing XOR checksum.
- Issues one write per word into a writable instruction RAM at byte address index*4.
- Holds the processor in reset (cpu_hold) while loading, so the processor fetches only after a complete, verified image.

Parameters:
- DEPTH, 101, number of instruction words in the memory; valid word indices 0..DEPTH-1
- WORD_W, 22, instruction width in bits
- ADDR_W, 22, address width; byte address, word-aligned (bits [1:0] always 0)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts the byte this cycle when in_valid && in_ready
- mem_we  output  1  instruction RAM write enable, one cycle per word
- mem_wa  output  ADDR_W  write byte address = index<<2
- mem_wd  output  WORD_W  write data
- cpu_hold  output  1  keeps the processor in reset while high
- busy  output  1  load in progress
- done  output  1  sticky: last load completed and verified
- err  output  1  sticky: last load aborted

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0, including cpu_hold, mem_wa, mem_wd, done and err. Word index, count and checksum registers are also 0.
- Stream format:
  - Byte 0: word count N.
  - Then N words of 3 bytes each, most significant byte first. The first byte of each word carries bits [21:16] in its [5:0]; its [7:6] must be 0.
  - Then 1 checksum byte = XOR of all preceding bytes, including N.
- States: IDLE, HDR, B0, B1, B2, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR + start -> HDR. On this transition: clear done and err, set busy and cpu_hold, reset the index to 0, checksum=0. start in any other state is ignored.
- in_ready=1 only in HDR, B0, B1, B2 and CHK. A byte is consumed only on in_valid&&in_ready. With no handshake the state holds indefinitely; there is no timeout.
- Every consumed byte is XORed into the running checksum. The checksum byte itself is compared, not accumulated.
- HDR: if N==0 or N>DEPTH -> ERR. Otherwise latch N and go to B0.
- B0: if byte[7:6]!=0 -> ERR. Otherwise latch [5:0] as word bits [21:16] -> B1.
- B1: latch bits [15:8] -> B2.
- B2: latch bits [7:0] -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_wa=index<<2, mem_wd=assembled word.
  - in_ready=0 in this state, so B0 of the next word is accepted at the earliest one cycle later.
  - If index==N-1 -> CHK; else index+1 -> B0.
- CHK: if byte==running checksum -> DONE; else -> ERR.
- DONE: done=1, busy=0, cpu_hold=0.
- ERR: err=1, busy=0, cpu_hold stays 1 so the processor does not run a partial image. Only a new start or reset leaves ERR.
- Outputs are registered.
  - mem_we is high only in WRITE. mem_wa and mem_wd hold their last value otherwise.
  - Latency from the third byte's handshake to mem_we is 1 cycle.
  - Minimum cycles per word is 4: 3 byte handshakes plus 1 WRITE cycle.
- Words already written before an error stay in the RAM. They are not cleared; err and cpu_hold make them unusable.
- Reset mid-load: abort immediately and return to the reset values, with cpu_hold=0. A partially written RAM is the system controller's responsibility.
- start and in_valid asserted in the same cycle in IDLE: only start takes effect. The byte is not consumed, since in_ready=0 in IDLE.

Decomposition:
- Package instr_loader_pkg:
  - state enum loader_state_t (IDLE..ERR)
  - constants WORD_W=22, BYTES_PER_WORD=3, MAX_WORDS=101, ADDR_SHIFT=2
- One sub-module, word_assembler:
  - shifts in 3 bytes and flags a bad top bits error
  - outputs the 22-bit word
  - the FSM drives its load and clear controls

Test Plan:
- Stream 02, 26 80 00, 26 80 F4, checksum 0x02^0x26^0x80^0x00^0x26^0x80^0xF4=0xF6, all with valid held high -> two mem_we pulses.
  - First pulse: wa=0x000000, wd=0x268000.
  - Second pulse: wa=0x000004, wd=0x2680F4.
  - Then done=1, cpu_hold=0, err=0.
- Same stream with in_valid toggling every other cycle -> identical writes and final flags, with no byte lost or duplicated.
- Header 0x00, and separately header 0x66 (102) -> err=1 one cycle after the header handshake, no mem_we, cpu_hold=1.
- Word first byte 0x40 -> err=1, no write for that word, in_ready=0 afterwards.
- Correct payload with the checksum byte inverted -> all N writes occur, then err=1, done=0, cpu_hold=1. A later start followed by a valid stream gives done=1 and err=0.
- rst_n pulled low between B1 and B2 -> all outputs 0 asynchronously. After release, start plus a valid stream completes normally from index 0.
